// File: rtl/bip_control.sv
// -----------------------------------------------------------------------------
// bip_control
//
// Instruction sequencer and decoder for the BIP accumulator processor.
// Fetches 16-bit instructions from a synchronous-read program memory, splits
// each into a 5-bit opcode and an 11-bit operand, and drives the control
// inputs of the accumulator datapath plus the data memory strobes. Owns the
// program counter, the instruction register and the run/halt state.
//
// Every instruction takes four cycles: FETCH, DECODE, MEM, EXEC.
//
// Ports:
//   i_clk         sole clock, rising edge
//   i_reset       asynchronous, active-low reset
//   i_start       run request, only acted on in IDLE
//   i_Instr       program memory read data, valid the cycle after o_PC
//   o_PC          program memory address
//   o_Operand     IR[10:0], datapath operand and data memory address
//   o_SelA        accumulator source: 00 data mem, 01 immediate, 10 ALU
//   o_SelB        ALU B source: 0 data mem, 1 immediate
//   o_WrAcc       accumulator write enable (EXEC only)
//   o_Op          ALU operation: 0 add, 1 subtract
//   o_WrRam       data memory write strobe (EXEC only)
//   o_RdRam       data memory read enable (MEM and EXEC)
//   o_busy        high in FETCH, DECODE, MEM and EXEC
//   o_halted      high in HALT
//   o_InstrCount  retired-instruction count, HLT and NOPs included
// -----------------------------------------------------------------------------
module bip_control #(
    parameter int NBITS_PC  = 11,
    parameter int NBITS_O   = 11,
    parameter int NBITS_OPC = 5,
    parameter int NBITS_I   = 16,
    parameter int NBITS_CNT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NBITS_I-1:0]   i_Instr,
    output logic [NBITS_PC-1:0]  o_PC,
    output logic [NBITS_O-1:0]   o_Operand,
    output logic [1:0]           o_SelA,
    output logic                 o_SelB,
    output logic                 o_WrAcc,
    output logic                 o_Op,
    output logic                 o_WrRam,
    output logic                 o_RdRam,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic [NBITS_CNT-1:0] o_InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    // Decoded control word for one opcode.
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;

    localparam logic [NBITS_OPC-1:0] OPC_HLT  = 5'b00000;
    localparam logic [NBITS_OPC-1:0] OPC_STO  = 5'b00001;
    localparam logic [NBITS_OPC-1:0] OPC_LD   = 5'b00010;
    localparam logic [NBITS_OPC-1:0] OPC_LDI  = 5'b00011;
    localparam logic [NBITS_OPC-1:0] OPC_ADD  = 5'b00100;
    localparam logic [NBITS_OPC-1:0] OPC_ADDI = 5'b00101;
    localparam logic [NBITS_OPC-1:0] OPC_SUB  = 5'b00110;
    localparam logic [NBITS_OPC-1:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] SEL_A_MEM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    // Unlisted opcodes (01000..11111) fall through as NOPs with no strobes.
    function automatic ctrl_t decode(input logic [NBITS_OPC-1:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_STO:  c.wr_ram = 1'b1;
            OPC_LD:   begin c.wr_acc = 1'b1; c.sel_a = SEL_A_MEM; c.rd_ram = 1'b1; end
            OPC_LDI:  begin c.wr_acc = 1'b1; c.sel_a = SEL_A_IMM; end
            OPC_ADD:  begin c.wr_acc = 1'b1; c.sel_a = SEL_A_ALU; c.rd_ram = 1'b1; end
            OPC_ADDI: begin c.wr_acc = 1'b1; c.sel_a = SEL_A_ALU; c.sel_b = 1'b1; end
            OPC_SUB:  begin c.wr_acc = 1'b1; c.sel_a = SEL_A_ALU; c.op = 1'b1; c.rd_ram = 1'b1; end
            OPC_SUBI: begin c.wr_acc = 1'b1; c.sel_a = SEL_A_ALU; c.sel_b = 1'b1; c.op = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t               state;
    logic [NBITS_I-1:0]   ir;
    logic [NBITS_OPC-1:0] ir_opc;
    ctrl_t                dec_fetched;
    ctrl_t                dec_ir;

    assign ir_opc      = ir[NBITS_I-1 -: NBITS_OPC];
    assign o_Operand   = ir[NBITS_O-1:0];
    // The selects for MEM are registered at the DECODE->MEM edge, the same
    // edge that loads IR, so they are decoded from the word being latched.
    assign dec_fetched = decode(i_Instr[NBITS_I-1 -: NBITS_OPC]);
    assign dec_ir      = decode(ir_opc);

    // NOTE: every register here uses non-blocking assignment so that all
    // state and outputs update together at the clock edge, regardless of
    // statement order inside the block.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            // Async clear drops every strobe immediately, so a reset that
            // lands in EXEC cannot complete a partial write.
            state        <= S_IDLE;
            ir           <= '0;
            o_PC         <= '0;
            o_InstrCount <= '0;
            o_SelA       <= '0;
            o_SelB       <= 1'b0;
            o_Op         <= 1'b0;
            o_WrAcc      <= 1'b0;
            o_WrRam      <= 1'b0;
            o_RdRam      <= 1'b0;
            o_busy       <= 1'b0;
            o_halted     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state  <= S_FETCH;
                        o_busy <= 1'b1;
                    end
                end

                // o_PC is already stable; program memory captures it here.
                S_FETCH: state <= S_DECODE;

                S_DECODE: begin
                    ir      <= i_Instr;
                    o_SelA  <= dec_fetched.sel_a;
                    o_SelB  <= dec_fetched.sel_b;
                    o_Op    <= dec_fetched.op;
                    o_RdRam <= dec_fetched.rd_ram;
                    state   <= S_MEM;
                end

                // Write strobes are raised for the EXEC cycle only.
                S_MEM: begin
                    o_WrAcc <= dec_ir.wr_acc;
                    o_WrRam <= dec_ir.wr_ram;
                    state   <= S_EXEC;
                end

                S_EXEC: begin
                    o_SelA       <= '0;
                    o_SelB       <= 1'b0;
                    o_Op         <= 1'b0;
                    o_WrAcc      <= 1'b0;
                    o_WrRam      <= 1'b0;
                    o_RdRam      <= 1'b0;
                    o_InstrCount <= o_InstrCount + 1'b1;
                    if (ir_opc == OPC_HLT) begin
                        state    <= S_HALT;
                        o_busy   <= 1'b0;
                        o_halted <= 1'b1;
                    end else begin
                        o_PC  <= o_PC + 1'b1;
                        state <= S_FETCH;
                    end
                end

                // Sticky until reset; i_start is ignored.
                S_HALT: state <= S_HALT;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control.sv
// -----------------------------------------------------------------------------
// tb_bip_control
//
// Directed bench for bip_control. Provides a synchronous program memory, a
// small accumulator datapath and a synchronous data memory so that program
// results can be checked as well as the control strobes cycle by cycle.
// Cycle n is the n-th cycle after the edge that samples i_start high.
// -----------------------------------------------------------------------------
module tb_bip_control;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] instr;
    logic [10:0] pc;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic        op;
    logic        wr_ram;
    logic        rd_ram;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    bip_control dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_Instr      (instr),
        .o_PC         (pc),
        .o_Operand    (operand),
        .o_SelA       (sel_a),
        .o_SelB       (sel_b),
        .o_WrAcc      (wr_acc),
        .o_Op         (op),
        .o_WrRam      (wr_ram),
        .o_RdRam      (rd_ram),
        .o_busy       (busy),
        .o_halted     (halted),
        .o_InstrCount (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory, synchronous read.
    logic [15:0] pmem [0:2047];
    always @(posedge clk) instr <= pmem[pc];

    // Datapath: accumulator + synchronous data memory.
    logic [15:0] dmem [0:2047];
    logic [15:0] acc;
    logic [15:0] rdata;
    logic [15:0] imm;
    logic [15:0] alu_b;
    logic        load_en;
    logic [10:0] load_addr;
    logic [15:0] load_data;

    assign imm   = {{5{operand[10]}}, operand};
    assign alu_b = sel_b ? imm : rdata;

    always @(posedge clk) begin
        if (load_en) dmem[load_addr] <= load_data;
        if (rd_ram) rdata <= dmem[operand];
        if (wr_ram) dmem[operand] <= acc;
        if (wr_acc) begin
            case (sel_a)
                2'b00:   acc <= rdata;
                2'b01:   acc <= imm;
                default: acc <= op ? (acc - alu_b) : (acc + alu_b);
            endcase
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // {SelA, SelB, Op, WrAcc, WrRam, RdRam}
    logic [6:0] ctl;
    assign ctl = {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Raise i_start for one edge (E0); afterwards we are in cycle 1.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic clear_pmem();
        for (int i = 0; i < 2048; i++) pmem[i] = 16'h0000;
    endtask

    task automatic preload(input logic [10:0] a, input logic [15:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    logic busy_ok;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        clear_pmem();

        // ---- Reset, idle with i_start low for 10 cycles ----
        do_reset();
        for (int i = 0; i < 10; i++) begin
            check("idle_ctl", {25'd0, ctl}, 32'h0);
            check("idle_pc", {21'd0, pc}, 32'h0);
            check("idle_flags", {30'd0, busy, halted}, 32'h0);
            check("idle_cnt", {16'd0, instr_count}, 32'h0);
            step();
        end

        // ---- LDI 5 / ADDI 3 / STO 0x010 / HLT ----
        pmem[0] = 16'h1805;
        pmem[1] = 16'h2803;
        pmem[2] = 16'h0810;
        pmem[3] = 16'h0000;
        pulse_start();
        check("p1_c1_busy", {31'd0, busy}, 32'h1);
        check("p1_c1_pc", {21'd0, pc}, 32'h0);
        run_to(3);
        check("p1_c3_ctl", {25'd0, ctl}, {25'd0, 7'b01_0_0_0_0_0});
        run_to(4);
        check("p1_c4_ctl", {25'd0, ctl}, {25'd0, 7'b01_0_0_1_0_0});
        run_to(5);
        check("p1_c5_ctl", {25'd0, ctl}, 32'h0);
        check("p1_c5_pc", {21'd0, pc}, 32'h1);
        check("p1_c5_acc", {16'd0, acc}, 32'd5);
        run_to(8);
        check("p1_c8_ctl", {25'd0, ctl}, {25'd0, 7'b10_1_0_1_0_0});
        run_to(12);
        check("p1_c12_ctl", {25'd0, ctl}, {25'd0, 7'b00_0_0_0_1_0});
        check("p1_c12_operand", {21'd0, operand}, 32'h010);
        run_to(16);
        check("p1_c16_ctl", {25'd0, ctl}, 32'h0);
        check("p1_c16_busy", {31'd0, busy}, 32'h1);
        run_to(17);
        check("p1_halt_flags", {30'd0, busy, halted}, 32'h1);
        check("p1_halt_pc", {21'd0, pc}, 32'h3);
        check("p1_halt_cnt", {16'd0, instr_count}, 32'd4);
        check("p1_mem010", {16'd0, dmem[16]}, 32'd8);
        // i_start is ignored while halted.
        start = 1'b1;
        run_to(20);
        start = 1'b0;
        check("p1_sticky_halt", {30'd0, busy, halted}, 32'h1);
        check("p1_sticky_pc", {21'd0, pc}, 32'h3);

        // ---- LD 0x020 / SUB 0x021 / HLT ----
        do_reset();
        check("p2_reset_pc", {21'd0, pc}, 32'h0);
        check("p2_reset_flags", {30'd0, busy, halted}, 32'h0);
        preload(11'h020, 16'd20);
        preload(11'h021, 16'd7);
        clear_pmem();
        pmem[0] = 16'h1020;
        pmem[1] = 16'h3021;
        pulse_start();
        run_to(3);
        check("p2_c3_ctl", {25'd0, ctl}, {25'd0, 7'b00_0_0_0_0_1});
        check("p2_c3_operand", {21'd0, operand}, 32'h020);
        run_to(4);
        check("p2_c4_ctl", {25'd0, ctl}, {25'd0, 7'b00_0_0_1_0_1});
        run_to(5);
        check("p2_c5_ctl", {25'd0, ctl}, 32'h0);
        run_to(7);
        check("p2_c7_ctl", {25'd0, ctl}, {25'd0, 7'b10_0_1_0_0_1});
        check("p2_c7_operand", {21'd0, operand}, 32'h021);
        run_to(8);
        check("p2_c8_ctl", {25'd0, ctl}, {25'd0, 7'b10_0_1_1_0_1});
        run_to(13);
        check("p2_halted", {31'd0, halted}, 32'h1);
        check("p2_acc", {16'd0, acc}, 32'd13);
        check("p2_cnt", {16'd0, instr_count}, 32'd3);

        // ---- Invalid opcode (NOP) then HLT ----
        do_reset();
        clear_pmem();
        pmem[0] = 16'hF800;
        pulse_start();
        run_to(3);
        check("p3_c3_ctl", {25'd0, ctl}, 32'h0);
        run_to(4);
        check("p3_c4_ctl", {25'd0, ctl}, 32'h0);
        check("p3_c4_pc", {21'd0, pc}, 32'h0);
        run_to(5);
        check("p3_c5_pc", {21'd0, pc}, 32'h1);
        run_to(9);
        check("p3_halted", {31'd0, halted}, 32'h1);
        check("p3_cnt", {16'd0, instr_count}, 32'd2);
        check("p3_pc", {21'd0, pc}, 32'h1);

        // ---- Reset in the EXEC cycle of ADDI ----
        do_reset();
        clear_pmem();
        pmem[0] = 16'h1805;
        pmem[1] = 16'h2803;
        pulse_start();
        run_to(8);
        check("p4_c8_wracc", {31'd0, wr_acc}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("p4_rst_ctl", {25'd0, ctl}, 32'h0);
        check("p4_rst_pc", {21'd0, pc}, 32'h0);
        check("p4_rst_flags", {30'd0, busy, halted}, 32'h0);
        check("p4_rst_cnt", {16'd0, instr_count}, 32'h0);
        @(posedge clk);
        #1;
        check("p4_acc_kept", {16'd0, acc}, 32'd5);
        rst_n = 1'b1;
        step();
        step();
        check("p4_idle_busy", {31'd0, busy}, 32'h0);
        pulse_start();
        check("p4_restart_pc", {21'd0, pc}, 32'h0);
        check("p4_restart_busy", {31'd0, busy}, 32'h1);
        run_to(4);
        check("p4_restart_ctl", {25'd0, ctl}, {25'd0, 7'b01_0_0_1_0_0});

        // ---- 2048 NOPs: PC wraps 2047 -> 0 ----
        do_reset();
        for (int i = 0; i < 2048; i++) pmem[i] = 16'hF800;
        pulse_start();
        busy_ok = 1'b1;
        while (cyc < 8192) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        check("p5_busy_all", {31'd0, busy_ok}, 32'h1);
        check("p5_c8192_pc", {21'd0, pc}, 32'd2047);
        step();
        check("p5_wrap_pc", {21'd0, pc}, 32'h0);
        check("p5_wrap_cnt", {16'd0, instr_count}, 32'd2048);
        check("p5_wrap_busy", {30'd0, busy, halted}, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
